// File: rtl/cla_nibble_sequencer_if.sv
// Requester-side bundle of cla_nibble_sequencer: start/operands in, busy/done/sum out.
// The master modport is the requester; the slave modport is the sequencer.
interface cla_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output start, A, B, C0,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, A, B, C0,
        output busy, done, S, Cout
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one external 4-bit CLA, feeding
// nibbles LSB-first and chaining the carry through carry_r.
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    cla_nibble_sequencer_if.slave  bus,
    output logic [3:0]             cla_A,
    output logic [3:0]             cla_B,
    output logic                   cla_C0,
    input  logic [3:0]             cla_S,
    input  logic                   cla_Cout
);
    localparam int unsigned NSTEPS = WIDTH / 4;
    localparam int unsigned IW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSTEPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_next;

    // acc_next already holds the final nibble on the last pass, so S takes it
    // whole; this also covers WIDTH=4 where acc_r has no lower bits to keep.
    always_comb begin
        acc_next = acc_r;
        acc_next[4*idx +: 4] = cla_S;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            bus.S    <= '0;
            bus.Cout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_r     <= bus.A;
                        b_r     <= bus.B;
                        carry_r <= bus.C0;
                        idx     <= '0;
                        state   <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r   <= acc_next;
                    carry_r <= cla_Cout;
                    if (idx == LAST) begin
                        bus.S    <= acc_next;
                        bus.Cout <= cla_Cout;
                        idx      <= '0;
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cla_A  = '0;
        cla_B  = '0;
        cla_C0 = 1'b0;
        if (state == ST_RUN) begin
            cla_A  = a_r[4*idx +: 4];
            cla_B  = b_r[4*idx +: 4];
            cla_C0 = carry_r;
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.done = (state == ST_DONE);
endmodule
